// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// one-cycle byte strobe and frame-error strobe.
module uart_byte_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 921_600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rxd_data,
    output logic       rx_en,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_rate
            $error("uart_byte_rx: CLKS_PER_BIT must be at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2, hist, armed;
    logic [1:0]    fill;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [1:0]    smp, smp_nxt;
    logic [7:0]    data_nxt;
    logic          en_nxt, err_nxt;
    logic          start_edge, maj, decide, wrap;

    // fill tracks when sync2 holds a real line sample rather than its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
            fill  <= 2'd0;
            armed <= 1'b0;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            hist  <= sync2;
            if (fill != 2'd2)
                fill <= fill + 2'd1;
            if (fill == 2'd2 && sync2)
                armed <= 1'b1;
        end
    end

    assign start_edge = armed & hist & ~sync2;
    assign maj        = (smp[0] & smp[1]) | (smp[0] & sync2) | (smp[1] & sync2);
    assign decide     = (cnt == C_DEC);
    assign wrap       = (cnt == C_LAST);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = wrap ? '0 : cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        smp_nxt     = smp;
        data_nxt    = rxd_data;
        en_nxt      = 1'b0;
        err_nxt     = 1'b0;
        if (cnt == C_S0)
            smp_nxt[0] = sync2;
        if (cnt == C_S1)
            smp_nxt[1] = sync2;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_edge) begin
                    state_nxt   = START;
                    // detection cycle already covers the first count of the bit
                    cnt_nxt     = CW'(1);
                    bit_cnt_nxt = 3'd0;
                end
            end
            START: begin
                if (decide && maj)
                    state_nxt = IDLE;
                else if (wrap)
                    state_nxt = DATA;
            end
            DATA: begin
                if (decide)
                    shreg_nxt = {maj, shreg[7:1]};
                if (wrap) begin
                    if (bit_cnt == 3'd7)
                        state_nxt = STOP;
                    else
                        bit_cnt_nxt = bit_cnt + 3'd1;
                end
            end
            STOP: begin
                if (decide) begin
                    state_nxt = IDLE;
                    if (maj) begin
                        data_nxt = shreg;
                        en_nxt   = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            smp       <= 2'b11;
            rxd_data  <= 8'h00;
            rx_en     <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            smp       <= smp_nxt;
            rxd_data  <= data_nxt;
            rx_en     <= en_nxt;
            frame_err <= err_nxt;
            rx_busy   <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] rxd_data;
    logic       rx_en, frame_err, rx_busy;

    int checks = 0, errors = 0;
    int cyc = 0, rx_cnt = 0, fe_cnt = 0, busy_cyc = 0, en_cyc = 0;
    int start_cyc = 0, lat, b_rx, b_fe, b_busy;
    logic [7:0] got_q[$];

    uart_byte_rx #(
        .CLK_FREQ (16_000_000),
        .BAUD_RATE(1_000_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .rxd_data (rxd_data),
        .rx_en    (rx_en),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_en) begin
            rx_cnt++;
            en_cyc = cyc;
            got_q.push_back(rxd_data);
        end
        if (frame_err)
            fe_cnt++;
        if (rx_busy)
            busy_cyc++;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            uart_rxd = 1'b1;
        end
    endtask

    task automatic send_bit(logic v, int gpos);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            uart_rxd = (j == gpos) ? ~v : v;
        end
    endtask

    task automatic send_byte(logic [7:0] b, logic stop, int gi, int gpos);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        start_cyc = cyc + 1;
        for (int i = 0; i < 10; i++)
            send_bit(fr[i], (i == gi) ? gpos : -1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_data", {24'd0, rxd_data}, 32'h00);
        chk("reset_en", {31'd0, rx_en}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        idle(6);

        // single frame and latency
        b_rx = rx_cnt; b_fe = fe_cnt;
        send_byte(8'hA5, 1'b1, -1, -1);
        idle(6);
        lat = en_cyc - start_cyc;
        chk("t1_count", rx_cnt - b_rx, 1);
        chk("t1_data", {24'd0, rxd_data}, 32'hA5);
        chk("t1_ferr", fe_cnt - b_fe, 0);
        chk("t1_busy", {31'd0, rx_busy}, 32'd0);
        chk("t1_latency", {31'd0, (lat >= 153 && lat <= 156)}, 32'd1);

        // back-to-back frames
        b_rx = rx_cnt; b_fe = fe_cnt;
        send_byte(8'h00, 1'b1, -1, -1);
        send_byte(8'hFF, 1'b1, -1, -1);
        send_byte(8'h55, 1'b1, -1, -1);
        idle(6);
        chk("t2_count", rx_cnt - b_rx, 3);
        if (rx_cnt - b_rx == 3) begin
            chk("t2_byte0", {24'd0, got_q[b_rx]}, 32'h00);
            chk("t2_byte1", {24'd0, got_q[b_rx+1]}, 32'hFF);
            chk("t2_byte2", {24'd0, got_q[b_rx+2]}, 32'h55);
        end
        chk("t2_ferr", fe_cnt - b_fe, 0);

        // short low pulse is a false start
        b_rx = rx_cnt; b_fe = fe_cnt; b_busy = busy_cyc;
        repeat (3) begin
            @(negedge clk);
            uart_rxd = 1'b0;
        end
        idle(30);
        chk("t3_no_en", rx_cnt - b_rx, 0);
        chk("t3_no_ferr", fe_cnt - b_fe, 0);
        chk("t3_busy_seen", {31'd0, (busy_cyc - b_busy) > 0}, 32'd1);
        chk("t3_busy_max", {31'd0, (busy_cyc - b_busy) <= 10}, 32'd1);
        send_byte(8'h3C, 1'b1, -1, -1);
        idle(6);
        chk("t3_data", {24'd0, rxd_data}, 32'h3C);
        chk("t3_count", rx_cnt - b_rx, 1);

        // bad stop bit
        send_byte(8'h81, 1'b1, -1, -1);
        idle(4);
        b_rx = rx_cnt; b_fe = fe_cnt;
        send_byte(8'h3C, 1'b0, -1, -1);
        idle(20);
        chk("t4_ferr", fe_cnt - b_fe, 1);
        chk("t4_no_en", rx_cnt - b_rx, 0);
        chk("t4_hold", {24'd0, rxd_data}, 32'h81);
        send_byte(8'h7E, 1'b1, -1, -1);
        idle(6);
        chk("t4_next", {24'd0, rxd_data}, 32'h7E);
        chk("t4_next_cnt", rx_cnt - b_rx, 1);

        // glitch at bit 2 centre
        b_rx = rx_cnt; b_fe = fe_cnt;
        send_byte(8'hF0, 1'b1, 3, 8);
        idle(6);
        chk("t5_data", {24'd0, rxd_data}, 32'hF0);
        chk("t5_count", rx_cnt - b_rx, 1);
        chk("t5_ferr", fe_cnt - b_fe, 0);

        // reset mid-byte with the line held low
        b_rx = rx_cnt; b_fe = fe_cnt;
        send_bit(1'b0, -1);
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        @(negedge clk);
        rst_n = 1'b0;
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        idle(20);
        chk("t6_quiet_en", rx_cnt - b_rx, 0);
        chk("t6_quiet_ferr", fe_cnt - b_fe, 0);
        send_byte(8'h96, 1'b1, -1, -1);
        idle(6);
        chk("t6_data", {24'd0, rxd_data}, 32'h96);
        chk("t6_count", rx_cnt - b_rx, 1);
        chk("t6_ferr", fe_cnt - b_fe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
